fp_normalize_pipe: RTL

Parametrised, pipelined normaliser for the FP add/sub datapath. It takes the raw 2×(MAN_W+1)-bit significand sum, the pre-normalisation exponent and the operand signs. It produces the normalised fraction, the adjusted exponent, the guard/round/sticky bits for the rounding stage, and underflow and overflow flags. It sits between the significand adder and the rounder, as a two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/fp_normalize_pipe_if.sv | 24 ++
 rtl/fp_normalize_pipe.sv | 106 ++++++++++
 2 files changed

// File: rtl/fp_normalize_pipe_if.sv
// fp_normalize_pipe_if: valid/ready bus between the significand adder, the normaliser and the rounder
// Ports: in_* carries one operation (sum, exponent, signs, carry, zero, sticky) with in_valid/in_ready;
//        out_* carries the normalised result (mant, exp, grs, flags) with out_valid/out_ready.
interface fp_normalize_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int SUM_W = 2 * (MAN_W + 1);
   logic in_valid, in_ready, in_sign1, in_sign2, in_carry, in_zero, in_sticky;
   logic [SUM_W-1:0] in_mant_sum;
   logic [EXP_W-1:0] in_exp;
   logic out_valid, out_ready, out_underflow, out_overflow;
   logic [MAN_W-1:0] out_mant;
   logic [EXP_W-1:0] out_exp;
   logic [2:0] out_grs;
   modport master (
      output in_valid, in_sign1, in_sign2, in_mant_sum, in_exp, in_carry, in_zero, in_sticky, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_grs, out_underflow, out_overflow
   );
   modport slave (
      input  in_valid, in_sign1, in_sign2, in_mant_sum, in_exp, in_carry, in_zero, in_sticky, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_grs, out_underflow, out_overflow
   );
endinterface

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage normaliser between the FP significand adder and the rounder
// Ports: clk; reset_n (async, active low); flush (sync, drops everything in flight);
//        bus (slave side of fp_normalize_pipe_if: operation in, normalised result + GRS + flags out).
module fp_normalize_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   fp_normalize_pipe_if.slave bus
);
   localparam int SUM_W = 2 * (MAN_W + 1);
   localparam int LZC_W = $clog2(SUM_W + 1);
   localparam int H     = SUM_W - 1;
   localparam int EW1   = EXP_W + 1;
   typedef enum logic [2:0] {C_ZERO, C_EXP0, C_OVF, C_CARRY, C_ADD, C_LSH, C_UFL} sel_e;
   logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_en, s2_en, eff_add;
   logic [LZC_W-1:0] lz_d, s1_lz_q, shamt_d, s1_shamt_q;
   logic [EW1-1:0]   exp_inc, exp_w;
   sel_e             sel_d, s1_sel_q;
   logic [SUM_W-1:0] s1_sum_q;
   logic [EXP_W-1:0] s1_exp_q, out_exp_d, out_exp_q;
   logic             s1_sticky_q, lost;
   logic [H-1:0]     sh;
   logic [MAN_W-1:0] out_mant_d, out_mant_q;
   logic [2:0]       out_grs_d, out_grs_q;
   logic             out_uf_d, out_uf_q, out_of_d, out_of_q;
   assign s2_en = ~s2_valid_q | bus.out_ready;
   assign s1_en = ~s1_valid_q | s2_en;
   assign bus.in_ready      = s1_en;
   assign bus.out_valid     = s2_valid_q;
   assign bus.out_mant      = out_mant_q;
   assign bus.out_exp       = out_exp_q;
   assign bus.out_grs       = out_grs_q;
   assign bus.out_underflow = out_uf_q;
   assign bus.out_overflow  = out_of_q;
   always_comb begin
      s1_valid_d = flush ? 1'b0 : s1_en ? bus.in_valid : s1_valid_q;
      s2_valid_d = flush ? 1'b0 : s2_en ? s1_valid_q : s2_valid_q;
   end
   // stage 1: leading-zero count, case classification and shift amount
   always_comb begin
      lz_d = LZC_W'(SUM_W);
      for (int i = 0; i < SUM_W; i++) if (bus.in_mant_sum[i]) lz_d = LZC_W'(SUM_W - 1 - i);
      eff_add = (bus.in_sign1 == bus.in_sign2) | bus.in_zero;
      exp_inc = {1'b0, bus.in_exp} + 1'b1;
      sel_d = (bus.in_exp == '0) ? C_EXP0 :
              eff_add ? (bus.in_carry ? ((exp_inc >= {1'b0, {EXP_W{1'b1}}}) ? C_OVF : C_CARRY) : C_ADD) :
              (bus.in_mant_sum == '0) ? C_ZERO :
              (32'(lz_d) < 32'(bus.in_exp)) ? C_LSH : C_UFL;
      // cancellation past the exponent stops at exp 1 so the result lands as a denormal
      shamt_d = (sel_d == C_LSH) ? lz_d : (sel_d == C_UFL) ? LZC_W'(bus.in_exp - 1'b1) : '0;
   end
   // stage 2: the hidden bit sits at sh's implied position H; the carry case is a right shift by one
   always_comb begin
      sh = (s1_sel_q == C_CARRY) ? s1_sum_q[H:1] : H'(s1_sum_q << s1_shamt_q);
      lost = (s1_sel_q == C_CARRY) & s1_sum_q[0];
      out_mant_d = ((s1_sel_q inside {C_ZERO, C_OVF}) || (s1_sel_q == C_EXP0 && s1_sum_q[H -: MAN_W] == '0)) ?
                   '0 : sh[H-1 -: MAN_W];
      out_grs_d = (s1_sel_q inside {C_ZERO, C_OVF}) ? 3'b000 :
                  {sh[H-MAN_W-1], sh[H-MAN_W-2], |sh[H-MAN_W-3:0] | s1_sticky_q | lost};
      exp_w = (s1_sel_q == C_EXP0)  ? EW1'(s1_sum_q[H]) :
              (s1_sel_q == C_CARRY) ? {1'b0, s1_exp_q} + 1'b1 :
              (s1_sel_q == C_ADD)   ? (s1_sum_q[H] ? {1'b0, s1_exp_q} : '0) :
              (s1_sel_q == C_LSH)   ? {1'b0, s1_exp_q} - EW1'(s1_lz_q) :
              (s1_sel_q == C_OVF)   ? {1'b0, {EXP_W{1'b1}}} : '0;
      out_exp_d = exp_w[EXP_W] ? '1 : exp_w[EXP_W-1:0];
      out_uf_d = s1_sel_q == C_UFL;
      out_of_d = s1_sel_q == C_OVF;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_exp_q    <= '0;
         s1_sticky_q <= 1'b0;
         s1_lz_q     <= '0;
         s1_shamt_q  <= '0;
         s1_sel_q    <= C_ZERO;
         out_mant_q  <= '0;
         out_exp_q   <= '0;
         out_grs_q   <= '0;
         out_uf_q    <= 1'b0;
         out_of_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s1_en) begin
            s1_sum_q    <= bus.in_mant_sum;
            s1_exp_q    <= bus.in_exp;
            s1_sticky_q <= bus.in_sticky;
            s1_lz_q     <= lz_d;
            s1_shamt_q  <= shamt_d;
            s1_sel_q    <= sel_d;
         end
         if (s2_en & s1_valid_q) begin
            out_mant_q <= out_mant_d;
            out_exp_q  <= out_exp_d;
            out_grs_q  <= out_grs_d;
            out_uf_q   <= out_uf_d;
            out_of_q   <= out_of_d;
         end
      end
endmodule
